pe_feeder: RTL
==============

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, sample/weight width; KERNEL, 3, taps per window (legal >= 2); PSUM_WIDTH, 16, partial-sum width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_valid  in  1  weight word strobe.
- w_data  in  DATA_WIDTH  weight word.
- w_loaded  out  1  all KERNEL weights held.
- start  in  1  begin frame.
- bias  in  PSUM_WIDTH  initial partial sum for the frame.
- s_valid  in  1  sample valid.
- s_data  in  DATA_WIDTH  sample.
- s_last  in  1  final sample of frame.
- s_ready  out  1  sample accept.
- pe_valid  out  1  window valid to PE chain.
- pe_data  out  KERNEL*DATA_WIDTH  window, slot 0 (LSBs) oldest.
- pe_weight  out  KERNEL*DATA_WIDTH  weights, slot k = k-th loaded word.
- pe_psum  out  PSUM_WIDTH  chain psum input.
- win_cnt  out  16  windows emitted this frame.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle frame-end pulse.
- err_short  out  1  last frame had fewer than KERNEL samples.

Function
REQ-003 SHALL implement states IDLE, FILL, STREAM, DONE.
REQ-004 In IDLE, w_valid SHALL write w_data to slot w_idx, increment w_idx; w_loaded SHALL set on the cycle after the KERNEL-th word.
REQ-005 w_valid while w_loaded=1 SHALL clear w_loaded and write that word to slot 0 (reload); w_valid outside IDLE SHALL be ignored.
REQ-006 start in IDLE with w_loaded=1 SHALL latch bias, clear win_cnt, fill count and err_short, and enter FILL next cycle; start with w_loaded=0 or outside IDLE SHALL be ignored.
REQ-007 start and w_valid in the same IDLE cycle: w_valid SHALL take effect, start SHALL be ignored.
REQ-008 s_ready SHALL be high exactly in FILL and STREAM (decoded from state); accepted beat = s_valid & s_ready.
REQ-009 Each accepted beat SHALL shift the window: slot i <= slot i+1, slot KERNEL-1 <= s_data.
REQ-010 FILL SHALL count accepted beats; the KERNEL-th beat completes the first window and SHALL move to STREAM.
REQ-011 For the window-completing beat in FILL and each accepted beat in STREAM, pe_valid SHALL be high for exactly one cycle on the next cycle, with pe_data the post-shift window; latency 1 cycle.
REQ-012 pe_valid SHALL be low on all other cycles; pe_data SHALL hold its last value; no window on cycles with s_valid low.
REQ-013 pe_weight SHALL be the registered weight slots; pe_psum SHALL be the latched bias, constant for the frame.
REQ-014 win_cnt SHALL increment with each pe_valid pulse, saturating at 16'hFFFF.
REQ-015 Accepted s_last in STREAM, or on the completing beat in FILL, SHALL emit its window normally and go to DONE.
REQ-016 Accepted s_last in FILL before KERNEL beats SHALL emit no window, set err_short, and go to DONE.
REQ-017 DONE SHALL last one cycle with done=1, s_ready=0, then return to IDLE; err_short SHALL hold until the next accepted start.
REQ-018 Weights and w_loaded SHALL persist across frames.

Reset
REQ-019 rst SHALL asynchronously force IDLE and zero all registers: weights, w_idx, w_loaded, window, bias, win_cnt, pe_valid, pe_data, pe_weight, pe_psum, s_ready, busy, done, err_short.
REQ-020 rst mid-frame SHALL abort immediately: no further pe_valid and no done pulse; w_loaded=0 afterward.

Verification
REQ-021 Load weights 1,2,3; start, bias=7; stream 10,20,30,40 (s_last on 40) -> two pe_valid pulses, windows {10,20,30} then {20,30,40}, pe_weight {1,2,3}, pe_psum=7, win_cnt=2, done one cycle after the 40 beat.
REQ-022 Load weights; stream 5,6 (s_last on 6) -> no pe_valid, err_short=1, done pulse, win_cnt=0.
REQ-023 Stream 1,2,3,4 with s_valid low for 2 cycles between 3 and 4 -> pe_valid only after the 3 and 4 beats, window {2,3,4}.
REQ-024 start with w_loaded=0 -> stays IDLE, s_ready=0; start with w_valid in the same cycle -> weight written, no frame.
REQ-025 Assert rst after 2nd window of 6-sample frame -> all outputs 0 next edge-independent, no done, w_loaded=0.
REQ-026 Load 4 words 1,2,3,9 -> w_loaded=0 after 9, slot 0=9; two more words -> w_loaded=1.

Source files
------------

// File: rtl/pe_feeder.sv
// ---------------------------------------------------------------------------
// pe_feeder
// Feeds a chain of processing elements with a sliding window of samples,
// the stored kernel weights and a per-frame bias as the starting partial sum.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   w_valid, w_data       weight word load (accepted only in IDLE)
//   w_loaded              all KERNEL weight slots hold valid words
//   start, bias           begin a frame, bias latched as pe_psum
//   s_valid, s_data,      sample stream; s_ready high in FILL and STREAM
//   s_last, s_ready
//   pe_valid, pe_data     one-cycle window strobe, slot 0 (LSBs) oldest
//   pe_weight, pe_psum    weight slots and frame bias toward the PE chain
//   win_cnt               windows emitted this frame (saturating)
//   busy, done            frame in progress / one-cycle frame-end pulse
//   err_short             last frame ended before the first window filled
//
// state  | meaning
// IDLE   | weight loading allowed, waiting for start
// FILL   | collecting the first KERNEL samples of the frame
// STREAM | every accepted sample emits one window
// DONE   | one-cycle frame end, done pulses
// ---------------------------------------------------------------------------
module pe_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int KERNEL     = 3,
   parameter int PSUM_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         w_valid,
   input  logic [DATA_WIDTH-1:0]        w_data,
   output logic                         w_loaded,
   input  logic                         start,
   input  logic [PSUM_WIDTH-1:0]        bias,
   input  logic                         s_valid,
   input  logic [DATA_WIDTH-1:0]        s_data,
   input  logic                         s_last,
   output logic                         s_ready,
   output logic                         pe_valid,
   output logic [KERNEL*DATA_WIDTH-1:0] pe_data,
   output logic [KERNEL*DATA_WIDTH-1:0] pe_weight,
   output logic [PSUM_WIDTH-1:0]        pe_psum,
   output logic [15:0]                  win_cnt,
   output logic                         busy,
   output logic                         done,
   output logic                         err_short
);

   localparam int KW = KERNEL * DATA_WIDTH;
   localparam int IW = $clog2(KERNEL);
   localparam int FW = $clog2(KERNEL + 1);
   localparam logic [IW-1:0] W_LAST = IW'(KERNEL - 1);
   localparam logic [FW-1:0] F_LAST = FW'(KERNEL - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state;
   logic [KW-1:0]   w_reg;
   logic [KW-1:0]   win;
   logic [KW-1:0]   win_shift;
   logic [IW-1:0]   w_idx;
   logic [FW-1:0]   fill_cnt;
   logic [PSUM_WIDTH-1:0] psum_r;
   logic [15:0]     win_cnt_inc;
   logic            beat;

   assign s_ready   = (state == FILL) || (state == STREAM);
   assign busy      = (state != IDLE);
   assign beat      = s_valid & s_ready;
   assign pe_weight = w_reg;
   assign pe_psum   = psum_r;

   // New sample enters the top slot, oldest sample drops out of slot 0.
   assign win_shift   = {s_data, win[KW-1:DATA_WIDTH]};
   assign win_cnt_inc = (win_cnt == 16'hFFFF) ? win_cnt : win_cnt + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         w_reg     <= '0;
         w_idx     <= '0;
         w_loaded  <= 1'b0;
         win       <= '0;
         fill_cnt  <= '0;
         psum_r    <= '0;
         win_cnt   <= '0;
         pe_valid  <= 1'b0;
         pe_data   <= '0;
         done      <= 1'b0;
         err_short <= 1'b0;
      end else begin
         pe_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               // A weight write wins over start in the same cycle.
               if (w_valid) begin
                  if (w_loaded) begin
                     // Writing into a full set restarts the load at slot 0.
                     w_loaded                <= 1'b0;
                     w_reg[DATA_WIDTH-1:0]   <= w_data;
                     w_idx                   <= IW'(1);
                  end else begin
                     for (int k = 0; k < KERNEL; k++) begin
                        if (int'(w_idx) == k)
                           w_reg[k*DATA_WIDTH +: DATA_WIDTH] <= w_data;
                     end
                     if (w_idx == W_LAST) begin
                        w_idx    <= '0;
                        w_loaded <= 1'b1;
                     end else begin
                        w_idx <= w_idx + 1'b1;
                     end
                  end
               end else if (start && w_loaded) begin
                  psum_r    <= bias;
                  win_cnt   <= '0;
                  fill_cnt  <= '0;
                  err_short <= 1'b0;
                  state     <= FILL;
               end
            end
            FILL: begin
               if (beat) begin
                  win <= win_shift;
                  if (fill_cnt == F_LAST) begin
                     pe_valid <= 1'b1;
                     pe_data  <= win_shift;
                     win_cnt  <= win_cnt_inc;
                     if (s_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= STREAM;
                     end
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                     if (s_last) begin
                        err_short <= 1'b1;
                        state     <= DONE;
                        done      <= 1'b1;
                     end
                  end
               end
            end
            STREAM: begin
               if (beat) begin
                  win      <= win_shift;
                  pe_valid <= 1'b1;
                  pe_data  <= win_shift;
                  win_cnt  <= win_cnt_inc;
                  if (s_last) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
